// File: rtl/dsp_int_arith.sv
// Integer helpers for the audio DSP chain: 16->32 sample extension, one's-complement
// reduced magnitude, and a multi-cycle digit-by-digit unsigned square root engine.
module dsp_int_arith #(
  parameter int RAD_W    = 32,
  parameter int EXT_FRAC = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic signed [15:0]      iSample,
  output logic signed [31:0]      oExt32,
  output logic        [15:0]      oRedAbs,
  input  logic        [RAD_W-1:0] iRad,
  input  logic                    iStart,
  output logic [RAD_W/2-1:0]      oRoot,
  output logic                    oBusy,
  output logic                    oDone
);

  localparam int ROOT_W = RAD_W / 2;
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // One's-complement magnitude: -n maps to n-1, so -32768 lands on 32767 without overflow.
  function automatic logic [15:0] red_abs(input logic signed [15:0] s);
    return s[15] ? ~s : s;
  endfunction

  assign oExt32  = {{(16-EXT_FRAC){iSample[15]}}, iSample, {EXT_FRAC{1'b0}}};
  assign oRedAbs = red_abs(iSample);

  state_t             r_state;
  logic [RAD_W-1:0]   r_rad;
  logic [REM_W-1:0]   r_rem;
  logic [ROOT_W-1:0]  r_root;
  logic [CNT_W-1:0]   r_cnt;

  logic [REM_W-1:0]   w_rem_sh;
  logic [REM_W-1:0]   w_trial;
  logic               w_ge;
  logic [REM_W-1:0]   w_rem_nx;
  logic [ROOT_W-1:0]  w_root_nx;

  // One restoring step: bring in the next two radicand bits and try subtracting 4*root+1.
  assign w_rem_sh  = (r_rem << 2) | REM_W'(r_rad[RAD_W-1 -: 2]);
  assign w_trial   = {r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nx = {r_root[ROOT_W-2:0], w_ge};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      oRoot   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (r_state == S_RUN) begin
        r_rad  <= r_rad << 2;
        r_rem  <= w_rem_nx;
        r_root <= w_root_nx;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          oRoot   <= w_root_nx;
          oDone   <= 1'b1;
          oBusy   <= 1'b0;
          r_state <= S_IDLE;
        end
      end
      // A start wins over everything else: it restarts a running root, or chains
      // onto one finishing on this very edge (whose oDone pulse still goes out).
      if (iStart) begin
        r_state <= S_RUN;
        oBusy   <= 1'b1;
        r_rad   <= iRad;
        r_rem   <= '0;
        r_root  <= '0;
        r_cnt   <= CNT_W'(ROOT_W);
      end
    end
  end

endmodule

// File: tb/tb_dsp_int_arith.sv
// Self-checking bench for dsp_int_arith: literal checks plus a cycle-level
// behavioural model of the square root handshake driven by random radicands.
module tb_dsp_int_arith;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [15:0] iSample = '0;
  logic [31:0] oExt32;
  logic [15:0] oRedAbs;
  logic [31:0] iRad = '0;
  logic        iStart = 1'b0;
  logic [15:0] oRoot;
  logic        oBusy;
  logic        oDone;

  dsp_int_arith #(.RAD_W(32), .EXT_FRAC(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSample(iSample), .oExt32(oExt32), .oRedAbs(oRedAbs),
    .iRad(iRad), .iStart(iStart), .oRoot(oRoot), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint isqrt(input longint x);
    real    rv;
    longint r;
    rv = real'(x);
    r  = longint'($rtoi($sqrt(rv)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Model: a start schedules a result 16 edges later; a new start replaces any pending one.
  int     m_left = 0;
  longint m_val = 0, m_root = 0, m_rad_pend = 0, m_rad_done = 0;
  bit     m_done = 1'b0;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_left = 0;
      m_root = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_root     = m_val;
          m_done     = 1'b1;
          m_rad_done = m_rad_pend;
        end
      end
      if (iStart) begin
        m_left     = 16;
        m_rad_pend = longint'(iRad);
        m_val      = isqrt(m_rad_pend);
      end
    end
  end

  always @(negedge iCLK) begin
    if (chk_en) begin
      longint r;
      chk("busy", oBusy, (m_left > 0));
      chk("done", oDone, m_done);
      chk("root", oRoot, m_root);
      if (oDone) begin
        r = longint'(oRoot);
        chk("root_bounds", ((r * r <= m_rad_done) && ((r + 1) * (r + 1) > m_rad_done)), 1);
      end
    end
  end

  task automatic comb_chk(input logic [15:0] s);
    int          v;
    logic [31:0] e;
    logic [15:0] a;
    iSample = s;
    #1;
    v = int'($signed(s));
    e = 32'(v * 16);
    a = 16'((v < 0) ? (-v - 1) : v);
    chk("ext_model", oExt32, e);
    chk("redabs_model", oRedAbs, a);
  endtask

  task automatic sqrt_lit(input logic [31:0] rad, input longint exp_root);
    int lat;
    @(posedge iCLK); #1 iRad = rad; iStart = 1'b1;
    @(posedge iCLK); #1 iStart = 1'b0; iRad = $urandom;
    lat = 0;
    while (!oDone && lat < 40) begin
      @(posedge iCLK); #1 lat++;
    end
    chk("sqrt_latency", lat, 16);
    chk("sqrt_value", oRoot, exp_root);
    @(posedge iCLK); #1;
    chk("done_single", oDone, 0);
    chk("sqrt_hold", oRoot, exp_root);
  endtask

  function automatic logic [31:0] rnd_rad();
    longint k;
    k = longint'($urandom_range(0, 65535));
    case ($urandom_range(0, 4))
      0:       return 32'(k * k);
      1:       return 32'(k * k - 1);
      2:       return 32'($urandom_range(0, 300));
      3:       return ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sel;
    #1 iRST = 1'b1;
    #1;
    chk("reset_busy", oBusy, 0);
    chk("reset_done", oDone, 0);
    chk("reset_root", oRoot, 0);
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    chk_en = 1'b1;

    // Extension and reduced-abs literals
    iSample = 16'h7FFF; #1 chk("ext_7fff", oExt32, 32'h0007_FFF0);
    iSample = 16'h8000; #1 chk("ext_8000", oExt32, 32'hFFF8_0000);
    iSample = 16'hFFFF; #1 chk("ext_ffff", oExt32, 32'hFFFF_FFF0);
    iSample = 16'h0000; #1 chk("ext_0",    oExt32, 32'h0);
    iSample = 16'd5;    #1 chk("abs_5",    oRedAbs, 5);
    iSample = 16'hFFFF; #1 chk("abs_m1",   oRedAbs, 0);
    iSample = 16'h8000; #1 chk("abs_min",  oRedAbs, 32767);
    iSample = 16'h7FFF; #1 chk("abs_max",  oRedAbs, 32767);
    iSample = 16'hFF9C; #1 chk("abs_m100", oRedAbs, 99);
    for (int i = 0; i < 300; i++) comb_chk(16'($urandom));

    chk("model_isqrt_1e6", isqrt(1000000), 1000);
    chk("model_isqrt_max", isqrt(64'hFFFF_FFFF), 65535);
    chk("model_isqrt_15", isqrt(15), 3);

    sqrt_lit(32'd1000000, 1000);
    sqrt_lit(32'd15, 3);
    sqrt_lit(32'd16, 4);
    sqrt_lit(32'd0, 0);
    sqrt_lit(32'hFFFF_FFFF, 65535);

    // Restart: a second start at edge 5 replaces the first computation
    @(posedge iCLK); #1 iRad = 32'd1000000; iStart = 1'b1;
    @(posedge iCLK); #1 iStart = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iRad = 32'd81; iStart = 1'b1;
    chk("restart_root_held", oRoot, 65535);
    @(posedge iCLK); #1 iStart = 1'b0; iRad = 32'd1000000;
    lat = 0;
    while (!oDone && lat < 40) begin
      @(posedge iCLK); #1 lat++;
    end
    chk("restart_latency", lat, 16);
    chk("restart_value", oRoot, 9);

    // Asynchronous reset at cycle 8 of a computation
    @(posedge iCLK); #1 iRad = 32'd1000000; iStart = 1'b1;
    @(posedge iCLK); #1 iStart = 1'b0;
    repeat (7) @(posedge iCLK);
    #1 chk("pre_reset_busy", oBusy, 1);
    #2 iRST = 1'b1;
    #1;
    chk("async_reset_busy", oBusy, 0);
    chk("async_reset_done", oDone, 0);
    chk("async_reset_root", oRoot, 0);
    @(posedge iCLK); #1 iRST = 1'b0;
    sqrt_lit(32'd49, 7);

    // Random sweep: mostly back-to-back starts, with occasional idle gaps and aborts
    for (int i = 0; i < 2400; i++) begin
      @(posedge iCLK); #1 iRad = rnd_rad(); iStart = 1'b1;
      @(posedge iCLK); #1 iStart = 1'b0; iRad = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      repeat (14 + $urandom_range(1, 4)) @(posedge iCLK);
      else if (sel == 1) repeat ($urandom_range(0, 12)) @(posedge iCLK);
      else               repeat (14) @(posedge iCLK);
    end
    repeat (20) @(posedge iCLK);
    #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
